regfile_bypass: RTL

Parametrised pipeline register file, the successor to the fixed 16×32 file. It provides three combinational read ports (A, B, D) and one synchronous write port. The top register serves as the program counter, with a hazard-gated load path and its own PC output. Optional same-cycle write-to-read bypass, an optional hard-wired zero register and a per-register pending-write scoreboard feed the control unit's hazard logic.

---
 rtl/rf_pkg.sv | 12 +
 rtl/regfile_bypass_if.sv | 29 ++
 rtl/rf_read_port.sv | 38 +++
 rtl/regfile_bypass.sv | 75 +++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared constants, select type and PC index helper for the pipeline register file.
package rf_pkg;
    localparam int RF_DATA_W = 32;
    localparam int RF_ADDR_W = 4;

    typedef logic [RF_ADDR_W-1:0] rf_sel_t;

    // The PC always lives in the highest-numbered register.
    function automatic int pc_idx(input int addr_w);
        return (1 << addr_w) - 1;
    endfunction
endpackage

// File: rtl/regfile_bypass_if.sv
// Register-file bus: three read ports, one write port, PC load path and issue/busy scoreboard signals.
interface regfile_bypass_if
    import rf_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W,
    parameter int ADDR_W = RF_ADDR_W
);
    logic [ADDR_W-1:0] SA, SB, SD;
    logic [DATA_W-1:0] PA, PB, PD;
    logic [ADDR_W-1:0] C;
    logic [DATA_W-1:0] PW;
    logic              RFLd;
    logic [DATA_W-1:0] PCin;
    logic              HZPCld;
    logic [DATA_W-1:0] PCout;
    logic              ISSUE;
    logic [ADDR_W-1:0] ISSUE_DST;
    logic              BUSY_A, BUSY_B, BUSY_D;

    modport master (
        output SA, SB, SD, C, PW, RFLd, PCin, HZPCld, ISSUE, ISSUE_DST,
        input  PA, PB, PD, PCout, BUSY_A, BUSY_B, BUSY_D
    );

    modport slave (
        input  SA, SB, SD, C, PW, RFLd, PCin, HZPCld, ISSUE, ISSUE_DST,
        output PA, PB, PD, PCout, BUSY_A, BUSY_B, BUSY_D
    );
endinterface

// File: rtl/rf_read_port.sv
// One combinational read mux with optional write forwarding, zero-register and busy masking.
// Latency 0; no backpressure.
module rf_read_port
    import rf_pkg::*;
#(
    parameter int DATA_W  = RF_DATA_W,
    parameter int ADDR_W  = RF_ADDR_W,
    parameter bit BYPASS  = 1'b1,
    parameter bit ZERO_R0 = 1'b0
) (
    input  logic [(1<<ADDR_W)-1:0][DATA_W-1:0] i_regs,
    input  logic [(1<<ADDR_W)-1:0]             i_busy,
    input  logic [ADDR_W-1:0]                  i_sel,
    input  logic                               i_wr_vld,
    input  logic [ADDR_W-1:0]                  i_wr_addr,
    input  logic [DATA_W-1:0]                  i_wr_dat,
    output logic [DATA_W-1:0]                  o_dat,
    output logic                               o_busy
);
    logic w_fwd;
    logic w_zero;

    // i_wr_vld already excludes discarded R0 writes and writes during reset.
    assign w_fwd  = BYPASS && i_wr_vld && (i_wr_addr == i_sel);
    assign w_zero = ZERO_R0 && (i_sel == '0);

    always_comb begin
        o_dat  = i_regs[i_sel];
        o_busy = i_busy[i_sel];
        if (w_zero) begin
            o_dat  = '0;
            o_busy = 1'b0;
        end else if (w_fwd) begin
            o_dat  = i_wr_dat;
            o_busy = 1'b0;
        end
    end
endmodule

// File: rtl/regfile_bypass.sv
// Parametrised register file with PC in the top register, write bypass and pending-write scoreboard.
// Reads combinational, writes/busy updates take effect at the next edge; no backpressure.
module regfile_bypass
    import rf_pkg::*;
#(
    parameter int DATA_W  = RF_DATA_W,
    parameter int ADDR_W  = RF_ADDR_W,
    parameter bit BYPASS  = 1'b1,
    parameter bit ZERO_R0 = 1'b0
) (
    input  logic             CLK,
    input  logic             RST,
    regfile_bypass_if.slave  bus
);
    localparam int                NREGS  = 1 << ADDR_W;
    localparam int                PC_IDX = pc_idx(ADDR_W);
    localparam logic [ADDR_W-1:0] PC_SEL = PC_IDX[ADDR_W-1:0];

    logic [NREGS-1:0][DATA_W-1:0] r_regs;
    logic [NREGS-1:0]             r_busy;
    logic [NREGS-1:0]             w_busy_nxt;
    logic                         w_wr_ok;

    // Writes seen while RST is high must not leak through the forwarding path.
    assign w_wr_ok = bus.RFLd && !RST && !(ZERO_R0 && (bus.C == '0));

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_regs <= '0;
        end else begin
            if (w_wr_ok && (bus.C != PC_SEL))
                r_regs[bus.C] <= bus.PW;
            if (w_wr_ok && (bus.C == PC_SEL))
                r_regs[PC_IDX] <= bus.PW;
            else if (bus.HZPCld)
                r_regs[PC_IDX] <= bus.PCin;
        end
    end

    // Clear first, then set, so a new producer supersedes the retiring one.
    always_comb begin
        w_busy_nxt = r_busy;
        if (bus.RFLd)
            w_busy_nxt[bus.C] = 1'b0;
        if (bus.ISSUE && !(ZERO_R0 && (bus.ISSUE_DST == '0)))
            w_busy_nxt[bus.ISSUE_DST] = 1'b1;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            r_busy <= '0;
        else
            r_busy <= w_busy_nxt;
    end

    assign bus.PCout = r_regs[PC_IDX];

    rf_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS(BYPASS), .ZERO_R0(ZERO_R0)) u_rp_a (
        .i_regs(r_regs), .i_busy(r_busy), .i_sel(bus.SA),
        .i_wr_vld(w_wr_ok), .i_wr_addr(bus.C), .i_wr_dat(bus.PW),
        .o_dat(bus.PA), .o_busy(bus.BUSY_A)
    );

    rf_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS(BYPASS), .ZERO_R0(ZERO_R0)) u_rp_b (
        .i_regs(r_regs), .i_busy(r_busy), .i_sel(bus.SB),
        .i_wr_vld(w_wr_ok), .i_wr_addr(bus.C), .i_wr_dat(bus.PW),
        .o_dat(bus.PB), .o_busy(bus.BUSY_B)
    );

    rf_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS(BYPASS), .ZERO_R0(ZERO_R0)) u_rp_d (
        .i_regs(r_regs), .i_busy(r_busy), .i_sel(bus.SD),
        .i_wr_vld(w_wr_ok), .i_wr_addr(bus.C), .i_wr_dat(bus.PW),
        .o_dat(bus.PD), .o_busy(bus.BUSY_D)
    );
endmodule
